// File: rtl/adc_pwr_ctrl.sv
// ADC and output-domain power sequencer: wakes the rails, restores retention state,
// fires one conversion per request, and saves/sleeps after idling in READY.
module adc_pwr_ctrl #(
   parameter int PWR_UP_CYC = 4,
   parameter int RET_CYC    = 2,
   parameter int IDLE_CYC   = 16,
   parameter int DONE_TMO   = 64
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       conv_req,
   input  logic [1:0] mode_req,
   input  logic       conv_done,
   output logic       Start,
   output logic       ADC_PWR_low,
   output logic       ADC_PWR_moderate,
   output logic       ADC_PWR_high,
   output logic       OUT_PWR,
   output logic       OUT_RET,
   output logic       OUT_RET_PWR,
   output logic       busy,
   output logic       err
);

   typedef enum logic [2:0] {
      SLEEP, WAKE, RESTORE, SETTLE, CONV, WAIT, READY, SAVE
   } state_t;

   localparam logic [7:0] PWR_LAST  = 8'(PWR_UP_CYC - 1);
   localparam logic [7:0] RET_LAST  = 8'(RET_CYC - 1);
   localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYC - 1);
   localparam logic [7:0] TMO_LAST  = 8'(DONE_TMO - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] mode_q, mode_d;
   logic       err_d, start_d, pwr_d, ret_d, busy_d;
   logic [2:0] rail_d;

   // Rail enable vector is {low, moderate, high}; mode 00 never reaches a rail.
   function automatic logic [2:0] rail_dec(input logic [1:0] m);
      case (m)
         2'b01:   rail_dec = 3'b100;
         2'b10:   rail_dec = 3'b010;
         2'b11:   rail_dec = 3'b001;
         default: rail_dec = 3'b000;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      err_d   = 1'b0;
      case (state_q)
         SLEEP: begin
            if (conv_req && (mode_req != 2'b00)) begin
               mode_d  = mode_req;
               state_d = WAKE;
            end
         end
         WAKE:    if (cnt_q == PWR_LAST) state_d = RESTORE;
         RESTORE: state_d = CONV;
         SETTLE:  if (cnt_q == PWR_LAST) state_d = CONV;
         CONV:    state_d = WAIT;
         WAIT: begin
            if (conv_done) begin
               state_d = READY;
            end else if (cnt_q == TMO_LAST) begin
               state_d = READY;
               err_d   = 1'b1;
            end
         end
         READY: begin
            if (conv_req) begin
               if (mode_req == 2'b00) begin
                  state_d = SAVE;
               end else if (mode_req == mode_q) begin
                  state_d = CONV;
               end else begin
                  mode_d  = mode_req;
                  state_d = SETTLE;
               end
            end else if (cnt_q == IDLE_LAST) begin
               state_d = SAVE;
            end
         end
         SAVE:    if (cnt_q == RET_LAST) state_d = SLEEP;
         default: state_d = SLEEP;
      endcase

      // Every state entry restarts the counter; it saturates rather than wrapping.
      if (state_d != state_q)   cnt_d = 8'd0;
      else if (cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
      else                      cnt_d = cnt_q;

      // Outputs are decoded from the next state so the registers line up with it.
      start_d = (state_d == CONV);
      pwr_d   = (state_d != SLEEP);
      ret_d   = (state_d inside {SLEEP, WAKE, SAVE});
      busy_d  = !(state_d inside {SLEEP, READY});
      rail_d  = pwr_d ? rail_dec(mode_d) : 3'b000;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q          <= SLEEP;
         cnt_q            <= 8'd0;
         mode_q           <= 2'b00;
         Start            <= 1'b0;
         ADC_PWR_low      <= 1'b0;
         ADC_PWR_moderate <= 1'b0;
         ADC_PWR_high     <= 1'b0;
         OUT_PWR          <= 1'b0;
         OUT_RET          <= 1'b1;
         OUT_RET_PWR      <= 1'b1;
         busy             <= 1'b0;
         err              <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         mode_q           <= mode_d;
         Start            <= start_d;
         ADC_PWR_low      <= rail_d[2];
         ADC_PWR_moderate <= rail_d[1];
         ADC_PWR_high     <= rail_d[0];
         OUT_PWR          <= pwr_d;
         OUT_RET          <= ret_d;
         OUT_RET_PWR      <= 1'b1;
         busy             <= busy_d;
         err              <= err_d;
      end
   end

endmodule

// File: tb/tb_adc_pwr_ctrl.sv
// Directed bench for adc_pwr_ctrl: the driver queues expected output changes with
// their cycle numbers, a negedge monitor compares each observed change against them.
module tb_adc_pwr_ctrl;

   logic       clk = 1'b0;
   logic       clr;
   logic       conv_req = 1'b0;
   logic [1:0] mode_req = 2'b00;
   logic       conv_done = 1'b0;
   logic       Start, ADC_PWR_low, ADC_PWR_moderate, ADC_PWR_high;
   logic       OUT_PWR, OUT_RET, OUT_RET_PWR, busy, err;

   adc_pwr_ctrl #(
      .PWR_UP_CYC(4), .RET_CYC(2), .IDLE_CYC(16), .DONE_TMO(64)
   ) dut (
      .clk(clk), .clr(clr), .conv_req(conv_req), .mode_req(mode_req),
      .conv_done(conv_done), .Start(Start), .ADC_PWR_low(ADC_PWR_low),
      .ADC_PWR_moderate(ADC_PWR_moderate), .ADC_PWR_high(ADC_PWR_high),
      .OUT_PWR(OUT_PWR), .OUT_RET(OUT_RET), .OUT_RET_PWR(OUT_RET_PWR),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // {Start, low, moderate, high, OUT_PWR, OUT_RET, OUT_RET_PWR, busy, err}
   localparam logic [8:0] SLEEP_V     = 9'b0_000_0_1_1_0_0;
   localparam logic [8:0] WAKE_M      = 9'b0_010_1_1_1_1_0;
   localparam logic [8:0] RESTORE_M   = 9'b0_010_1_0_1_1_0;
   localparam logic [8:0] CONV_M      = 9'b1_010_1_0_1_1_0;
   localparam logic [8:0] READY_M     = 9'b0_010_1_0_1_0_0;
   localparam logic [8:0] SAVE_M      = 9'b0_010_1_1_1_1_0;
   localparam logic [8:0] WAKE_L      = 9'b0_100_1_1_1_1_0;
   localparam logic [8:0] RESTORE_L   = 9'b0_100_1_0_1_1_0;
   localparam logic [8:0] CONV_L      = 9'b1_100_1_0_1_1_0;
   localparam logic [8:0] READY_L     = 9'b0_100_1_0_1_0_0;
   localparam logic [8:0] READY_L_ERR = 9'b0_100_1_0_1_0_1;
   localparam logic [8:0] SAVE_L      = 9'b0_100_1_1_1_1_0;
   localparam logic [8:0] SETTLE_H    = 9'b0_001_1_0_1_1_0;
   localparam logic [8:0] CONV_H      = 9'b1_001_1_0_1_1_0;
   localparam logic [8:0] READY_H     = 9'b0_001_1_0_1_0_0;
   localparam logic [8:0] SAVE_H      = 9'b0_001_1_1_1_1_0;

   typedef struct {
      int         cyc;
      logic [8:0] v;
   } exp_t;

   exp_t       q[$];
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   logic [8:0] vec;
   logic [8:0] prev = SLEEP_V;

   assign vec = {Start, ADC_PWR_low, ADC_PWR_moderate, ADC_PWR_high,
                 OUT_PWR, OUT_RET, OUT_RET_PWR, busy, err};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (vec !== prev) begin
         total = total + 1;
         if (q.size() == 0) begin
            bad = bad + 1;
            $display("FAIL unexpected_change cyc=%0d got=%b prev=%b want=no change", cyc, vec, prev);
         end else begin
            e = q.pop_front();
            if ((e.cyc != cyc) || (e.v !== vec)) begin
               bad = bad + 1;
               $display("FAIL out_change got=%b@%0d want=%b@%0d", vec, cyc, e.v, e.cyc);
            end
         end
         prev = vec;
      end
   end

   task automatic expect_at(input int c, input logic [8:0] v);
      exp_t e;
      e.cyc = c;
      e.v   = v;
      q.push_back(e);
   endtask

   task automatic at(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d pending=%0d want=finished", cyc, q.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b, c, d;
      clr = 1'b1;
      #7;
      total = total + 1;
      if (vec !== SLEEP_V) begin
         bad = bad + 1;
         $display("FAIL reset_state got=%b want=%b", vec, SLEEP_V);
      end
      repeat (2) @(negedge clk);

      // Wake in moderate mode, convert, idle out to SLEEP.
      b = cyc;
      clr = 1'b0; conv_req = 1'b1; mode_req = 2'b10;
      expect_at(b + 1,  WAKE_M);
      expect_at(b + 5,  RESTORE_M);
      expect_at(b + 6,  CONV_M);
      expect_at(b + 7,  RESTORE_M);
      expect_at(b + 9,  READY_M);
      expect_at(b + 25, SAVE_M);
      expect_at(b + 27, SLEEP_V);
      at(b + 6);  conv_req = 1'b0;
      at(b + 8);  conv_done = 1'b1;
      at(b + 9);  conv_done = 1'b0;
      // Mode-00 request and stray conv_done in SLEEP must change nothing.
      at(b + 30); conv_req = 1'b1; mode_req = 2'b00;
      at(b + 31); conv_done = 1'b1;
      at(b + 32); conv_req = 1'b0; conv_done = 1'b0;

      // Low mode with timeout, rail switch to high, timeout-edge done, mode-00 save.
      c = b + 34;
      at(c); conv_req = 1'b1; mode_req = 2'b01;
      expect_at(c + 1,   WAKE_L);
      expect_at(c + 5,   RESTORE_L);
      expect_at(c + 6,   CONV_L);
      expect_at(c + 7,   RESTORE_L);
      expect_at(c + 71,  READY_L_ERR);
      expect_at(c + 72,  READY_L);
      expect_at(c + 76,  SETTLE_H);
      expect_at(c + 80,  CONV_H);
      expect_at(c + 81,  SETTLE_H);
      expect_at(c + 83,  READY_H);
      expect_at(c + 86,  CONV_H);
      expect_at(c + 87,  SETTLE_H);
      expect_at(c + 151, READY_H);
      expect_at(c + 154, SAVE_H);
      expect_at(c + 156, SLEEP_V);
      at(c + 6);   conv_req = 1'b0;
      at(c + 72);  conv_done = 1'b1;
      at(c + 73);  conv_done = 1'b0;
      at(c + 75);  conv_req = 1'b1; mode_req = 2'b11;
      at(c + 80);  conv_req = 1'b0;
      at(c + 82);  conv_done = 1'b1;
      at(c + 83);  conv_done = 1'b0;
      at(c + 85);  conv_req = 1'b1;
      at(c + 86);  conv_req = 1'b0;
      at(c + 150); conv_done = 1'b1;
      at(c + 151); conv_done = 1'b0;
      at(c + 153); conv_req = 1'b1; mode_req = 2'b00;
      at(c + 154); conv_req = 1'b0;

      // Asynchronous clear mid-WAIT, quiet aftermath, then a clean new request.
      d = c + 160;
      at(d); conv_req = 1'b1; mode_req = 2'b10;
      expect_at(d + 1, WAKE_M);
      expect_at(d + 5, RESTORE_M);
      expect_at(d + 6, CONV_M);
      expect_at(d + 7, RESTORE_M);
      at(d + 6); conv_req = 1'b0;
      at(d + 10);
      @(posedge clk);
      #2;
      expect_at(cyc, SLEEP_V);
      clr = 1'b1;
      at(d + 13); clr = 1'b0;
      at(d + 90); conv_req = 1'b1; mode_req = 2'b01;
      expect_at(d + 91,  WAKE_L);
      expect_at(d + 95,  RESTORE_L);
      expect_at(d + 96,  CONV_L);
      expect_at(d + 97,  RESTORE_L);
      expect_at(d + 99,  READY_L);
      expect_at(d + 115, SAVE_L);
      expect_at(d + 117, SLEEP_V);
      at(d + 96); conv_req = 1'b0;
      at(d + 98); conv_done = 1'b1;
      at(d + 99); conv_done = 1'b0;
      at(d + 125);

      total = total + 1;
      if (q.size() != 0) begin
         bad = bad + 1;
         $display("FAIL pending_expectations got=%0d want=0 (next at cyc %0d)", q.size(), q[0].cyc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
